// File: rtl/ll_window_scheduler.sv
// Shared line-length engine: one |x[i]-x[i-1]| datapath time-multiplexed over
// NUM_CH round-robin requesters, emitting one windowed sum per WIN_LEN diffs.
module ll_window_scheduler #(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 4,
  parameter int WIN_LEN = 256,
  localparam int CH_W   = $clog2(NUM_CH),
  localparam int CNT_W  = $clog2(WIN_LEN),
  localparam int ACC_W  = DATA_W + 1 + CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [ACC_W-1:0]         out_sum
);

  logic [CH_W-1:0]   ptr_reg;
  logic [DATA_W-1:0] prev_reg [NUM_CH];
  logic [NUM_CH-1:0] primed_reg;
  logic [ACC_W-1:0]  acc_reg  [NUM_CH];
  logic [CNT_W-1:0]  cnt_reg  [NUM_CH];
  logic              out_valid_reg;
  logic [CH_W-1:0]   out_ch_reg;
  logic [ACC_W-1:0]  out_sum_reg;

  logic              gnt_any;
  logic [CH_W-1:0]   gnt_ch;
  int                arb_idx;
  logic              stall;
  logic              accept;
  logic              win_done;
  logic              complete;
  logic [CH_W-1:0]   ptr_next;
  logic [DATA_W-1:0] sample;
  logic [DATA_W:0]   diff_s;
  logic [DATA_W:0]   mag;
  logic [ACC_W-1:0]  sum_next;

  // Search downward so the last hit written is the one nearest to ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    arb_idx = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      arb_idx = int'(ptr_reg) + k;
      if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
      if (req_valid[arb_idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = CH_W'(arb_idx);
      end
    end
  end

  assign stall  = out_valid_reg & ~out_ready;
  assign accept = gnt_any & ~stall;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign req_ready[gi] = accept & (gnt_ch == CH_W'(gi));
    end
  endgenerate

  assign ptr_next = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);

  // Sign-extend both operands one bit so the difference never wraps.
  assign sample   = req_data[gnt_ch*DATA_W +: DATA_W];
  assign diff_s   = {sample[DATA_W-1], sample} - {prev_reg[gnt_ch][DATA_W-1], prev_reg[gnt_ch]};
  assign mag      = diff_s[DATA_W] ? -diff_s : diff_s;
  assign sum_next = acc_reg[gnt_ch] + ACC_W'(mag);
  assign win_done = (cnt_reg[gnt_ch] == CNT_W'(WIN_LEN - 1));
  assign complete = accept & primed_reg[gnt_ch] & win_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      primed_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      out_sum_reg   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        prev_reg[c] <= '0;
        acc_reg[c]  <= '0;
        cnt_reg[c]  <= '0;
      end
    end else begin
      if (accept) begin
        ptr_reg            <= ptr_next;
        prev_reg[gnt_ch]   <= sample;
        primed_reg[gnt_ch] <= 1'b1;
        if (primed_reg[gnt_ch]) begin
          if (win_done) begin
            acc_reg[gnt_ch] <= '0;
            cnt_reg[gnt_ch] <= '0;
          end else begin
            acc_reg[gnt_ch] <= sum_next;
            cnt_reg[gnt_ch] <= cnt_reg[gnt_ch] + CNT_W'(1);
          end
        end
      end
      // A new completion wins over a same-cycle handshake of the old result.
      if (complete) begin
        out_valid_reg <= 1'b1;
        out_ch_reg    <= gnt_ch;
        out_sum_reg   <= sum_next;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;
  assign out_sum   = out_sum_reg;

endmodule
